// File: rtl/branch_predictor_unit.sv
// Bimodal predictor + direct-mapped BTB; BP_PERF_CNT_EN adds branch/mispredict counters.
// Latency: prediction 1 cycle after pred_req; mispredict/redirect 1 cycle after upd_valid.
// Backpressure: none; every input is sampled every cycle and lookups read pre-update state.
module branch_predictor_unit #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4,
    parameter int TAG_W = WIDTH - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_req,
    input  logic [WIDTH-1:0] pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_pred_taken,
    input  logic [WIDTH-1:0] upd_pred_target,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);
    localparam int ENTRIES = 2**IDX_W;

    logic [ENTRIES-1:0] btb_vld;
    logic [1:0]         ctr     [ENTRIES];
    logic [TAG_W-1:0]   btb_tag [ENTRIES];
    logic [WIDTH-1:0]   btb_tgt [ENTRIES];

    logic [IDX_W-1:0] pred_idx, upd_idx;
    logic [TAG_W-1:0] pred_tag, upd_tag;
    logic             pred_hit, upd_hit, pred_dir, mispred_cond;
    logic [WIDTH-1:0] pred_nxt, redirect_nxt;
    logic             unused_pc_lsb;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign pred_tag = pred_pc[WIDTH-1:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[WIDTH-1:IDX_W+2];
    assign unused_pc_lsb = ^{pred_pc[1:0], upd_pc[1:0]};

    assign pred_hit = btb_vld[pred_idx] && (btb_tag[pred_idx] == pred_tag);
    assign upd_hit  = btb_vld[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign pred_dir = pred_hit && ctr[pred_idx][1];
    assign pred_nxt = pred_dir ? btb_tgt[pred_idx] : pred_pc + WIDTH'(4);

    assign mispred_cond = (upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target));
    assign redirect_nxt = upd_taken ? upd_target : upd_pc + WIDTH'(4);

    // Direction state: valid bits and saturating counters need reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_vld <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken && ctr[upd_idx] != 2'b11)
                    ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
                else if (!upd_taken && ctr[upd_idx] != 2'b00)
                    ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end else if (upd_taken) begin
                btb_vld[upd_idx] <= 1'b1;
                ctr[upd_idx]     <= 2'b10;
            end
        end
    end

    // Tag rewrite on a taken hit is harmless: it already matches.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[upd_idx] <= upd_tag;
            btb_tgt[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_taken  <= pred_dir;
                pred_target <= pred_nxt;
            end
            mispredict <= upd_valid && mispred_cond;
            if (upd_valid) redirect_pc <= redirect_nxt;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispred_cond) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Random + directed bench for branch_predictor_unit against a table-level reference model.
module tb_branch_predictor_unit;
    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pred_req = 1'b0;
    logic [W-1:0]  pred_pc = '0;
    logic          pred_valid, pred_taken;
    logic [W-1:0]  pred_target;
    logic          upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic [W-1:0]  upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic          mispredict;
    logic [W-1:0]  redirect_pc;
    logic [31:0]   branch_cnt, mispred_cnt;

    branch_predictor_unit dut (
        .clk(clk), .rst_n(rst_n),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one entry per index, counter kept as an integer 0..3.
    bit           m_v   [N];
    int           m_ctr [N];
    logic [W-1:0] m_tag [N];
    logic [W-1:0] m_tgt [N];
    logic         e_pv, e_pt, e_mis;
    logic [W-1:0] e_ptgt, e_rpc;
    logic [31:0]  e_bc, e_mc;

    always @(posedge clk or negedge rst_n) begin
        int  idx;
        bit  hit, cond;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_v[i]   = 1'b0;
                m_ctr[i] = 1;
            end
            e_pv = 0; e_pt = 0; e_ptgt = '0; e_mis = 0; e_rpc = '0; e_bc = '0; e_mc = '0;
        end else begin
            e_pv = pred_req;
            if (pred_req) begin
                idx    = int'((pred_pc / 4) % N);
                hit    = m_v[idx] && (m_tag[idx] == pred_pc / (4 * N));
                e_pt   = hit && (m_ctr[idx] >= 2);
                e_ptgt = e_pt ? m_tgt[idx] : pred_pc + 32'd4;
            end
            e_mis = 1'b0;
            if (upd_valid) begin
                cond  = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target);
                e_mis = cond;
                e_rpc = upd_taken ? upd_target : upd_pc + 32'd4;
`ifdef BP_PERF_CNT_EN
                e_bc = e_bc + 1;
                if (cond) e_mc = e_mc + 1;
`endif
                idx = int'((upd_pc / 4) % N);
                hit = m_v[idx] && (m_tag[idx] == upd_pc / (4 * N));
                if (hit) m_ctr[idx] = upd_taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                                 : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                else if (upd_taken) begin
                    m_v[idx]   = 1'b1;
                    m_tag[idx] = upd_pc / (4 * N);
                    m_ctr[idx] = 2;
                end
                if (upd_taken) m_tgt[idx] = upd_target;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_pv});
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
            chk("pred_target", pred_target, e_ptgt);
            chk("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
            chk("redirect_pc", redirect_pc, e_rpc);
            chk("branch_cnt", branch_cnt, e_bc);
            chk("mispred_cnt", mispred_cnt, e_mc);
        end
    end

    // Applies one cycle of inputs; returns at the following falling edge.
    task automatic drive(input bit rq, input logic [W-1:0] ppc, input bit uv,
                         input logic [W-1:0] upc, input bit ut, input logic [W-1:0] utgt,
                         input bit upt, input logic [W-1:0] uptgt);
        pred_req = rq; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt;
        @(negedge clk);
    endtask

    task automatic look(input logic [W-1:0] pc);
        drive(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic upd(input logic [W-1:0] pc, input bit t, input logic [W-1:0] tgt,
                       input bit pt, input logic [W-1:0] ptgt);
        drive(1'b0, '0, 1'b1, pc, t, tgt, pt, ptgt);
    endtask

    task automatic expect_pred(input string name, input bit t, input logic [W-1:0] tgt);
        chk({name, "_valid"}, {31'd0, pred_valid}, 32'd1);
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({name, "_target"}, pred_target, tgt);
    endtask

    initial begin
        logic [W-1:0] pc, tgt;
        bit t, pt;
        repeat (3) @(negedge clk);
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        look(32'h100);                               expect_pred("cold", 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        chk("alloc_mis", {31'd0, mispredict}, 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h80);
        look(32'h100);                               expect_pred("hit", 1'b1, 32'h80);
        chk("no_upd_mis", {31'd0, mispredict}, 32'd0);
        look(32'h140);                               expect_pred("alias", 1'b0, 32'h144);
        repeat (3) upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("sat_no_mis", {31'd0, mispredict}, 32'd0);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("nt_mis", {31'd0, mispredict}, 32'd1);
        chk("nt_redirect", redirect_pc, 32'h104);
        look(32'h100);                               expect_pred("ctr10", 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        look(32'h100);                               expect_pred("ctr01", 1'b0, 32'h104);
        drive(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        expect_pred("rbw", 1'b0, 32'h204);
        chk("rbw_redirect", redirect_pc, 32'h300);
        look(32'h200);                               expect_pred("rbw_after", 1'b1, 32'h300);
        look(32'hFFFF_FFFC);                         expect_pred("wrap", 1'b0, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            pc  = (i % 97 == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'($urandom_range(0, 47)) * 4;
            t   = ($urandom_range(0, 3) != 0);
            tgt = 32'h2000 + 32'($urandom_range(0, 3)) * 16;
            pt  = $urandom_range(0, 1) == 1;
            drive($urandom_range(0, 2) != 0, 32'h1000 + 32'($urandom_range(0, 47)) * 4,
                  $urandom_range(0, 1) == 1, pc, t, tgt, pt,
                  ($urandom_range(0, 2) != 0) ? tgt : 32'h2040);
        end

        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        drive(1'b1, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("pre_rst_valid", {31'd0, pred_valid}, 32'd1);
        pred_req = 1'b1; pred_pc = 32'h100;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("arst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("arst_branch_cnt", branch_cnt, 32'd0);
        chk("arst_mispred_cnt", mispred_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("dropped_req", {31'd0, pred_valid}, 32'd0);
        look(32'h100);                               expect_pred("post_rst", 1'b0, 32'h104);
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
